arith_op_sequencer: RTL and testbench
=====================================

Name: arith_op_sequencer

Overview:
- Command-issue stage directly upstream of arithunit: buffers operand/op commands, drives arithunit's data_1/data_2/op_sel, waits the unit's latency, captures data_out, and returns it on a valid/ready response port.
- Decouples producers (bench or control logic) from arithunit timing and lets them queue up to DEPTH operations back-to-back.

Parameters:
- DATA_W, 16, operand/result width (matches arithunit).
- OP_W, 2, op_sel width.
- LAT, 1, clock edges from au_* input change to valid au_data_out (0 = combinational unit); range 0..15.
- DEPTH, 4, command FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_data_1  in  DATA_W  operand 1.
- cmd_data_2  in  DATA_W  operand 2.
- cmd_op_sel  in  OP_W  operation select.
- au_data_1  out  DATA_W  to arithunit data_1.
- au_data_2  out  DATA_W  to arithunit data_2.
- au_op_sel  out  OP_W  to arithunit op_sel.
- au_data_out  in  DATA_W  from arithunit data_out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DATA_W  captured result.
- rsp_op_sel  out  OP_W  op_sel of that result.
- busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset (sync, high): FIFO emptied, state=IDLE, au_*=0, rsp_valid=0, rsp_data=0, rsp_op_sel=0, cnt=0. Reset mid-operation discards queued and in-flight commands. Any pending response is dropped. arithunit reset is not driven by this block.
- Push: cmd_valid && cmd_ready at an edge. Push and pop in the same cycle are legal; count is unchanged. No push when full. FIFO is registered: a command pushed into an empty FIFO is popped at the next edge at earliest.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if FIFO non-empty, pop at edge E0, load au_* from the head entry, cnt<=LAT, go to WAIT.
- WAIT: at each edge, if cnt!=0 then cnt<=cnt-1. If cnt==0, capture rsp_data<=au_data_out, set rsp_op_sel, set rsp_valid<=1, go to RESP. Capture happens at edge E0+LAT+1.
- RESP: rsp_valid, rsp_data and rsp_op_sel are held stable until rsp_ready. At the handshake edge, rsp_valid<=0. If the FIFO is non-empty at that edge, pop in the same edge and go to WAIT (back-to-back, no IDLE cycle); otherwise go to IDLE.
- Throughput: one op per LAT+2 cycles with continuous rsp_ready and a non-empty FIFO.
- au_* hold their last values between ops. They change only on pop.
- Data is passed unmodified; no width conversion. The result is whatever arithunit produces.
- FIFO pointers are log2(DEPTH) bits with an extra wrap bit. Wrap-around is transparent. full = DEPTH entries.
- cmd_ready depends only on registered count; there is no combinational path from rsp_ready.

Optional Feature:
- Macro: SEQ_STATS_EN.
- Defined: adds output stat_done [15:0] and output stat_stall [15:0], both reset to 0.
  - stat_done increments on each response handshake and wraps 0xFFFF->0x0000.
  - stat_stall increments each cycle rsp_valid && !rsp_ready and saturates at 0xFFFF.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Test Plan:
- Single op: bench arithunit model registered, op 0 = add, LAT=1. Push (3,4,op0) at edge T.
  - Pop at T+1.
  - rsp_valid=1, rsp_data=7, rsp_op_sel=0 after edge T+3.
  - busy=0 after handshake.
- Fill/full: rsp_ready=0, push 5 commands with DEPTH=4. One is popped into WAIT, the FIFO then holds 4 and cmd_ready=0.
  - The 6th push is refused.
  - Releasing rsp_ready yields 5 results in push order, spaced LAT+2 cycles apart.
- Back-pressure: hold rsp_ready=0 for 10 cycles while in RESP.
  - rsp_data and rsp_op_sel stay constant; no pop occurs.
  - With SEQ_STATS_EN defined, stat_stall=10.
- Simultaneous push/pop: FIFO at 2 entries, push while the RESP handshake pops. Count stays 2 and order is preserved.
- Reset mid-op: assert reset for 1 cycle during WAIT with 3 queued commands.
  - Next cycle: rsp_valid=0, busy=0, au_*=0, cmd_ready=1.
  - No stale result appears afterwards.
- LAT=0 variant: combinational add model, push (9,1,op0). rsp_data=10 captured at pop edge +1.

Source files
------------

// File: rtl/arith_op_sequencer.sv
// ---------------------------------------------------------------------------
// arith_op_sequencer
//
// Command-issue stage that sits directly in front of arithunit. It queues
// operand/op commands in a small FIFO and issues them to the unit one at a
// time. For each command it waits the unit's latency, captures the result,
// and returns it on a valid/ready response port.
//
// Parameters:
//   DATA_W - operand/result width
//   OP_W   - op_sel width
//   LAT    - clock edges from an au_* change to a valid au_data_out (0..15)
//   DEPTH  - command FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, reset              - single clock; synchronous active-high reset
//   cmd_valid/cmd_ready     - command handshake (cmd_ready = FIFO not full)
//   cmd_data_1/2, cmd_op_sel- command payload
//   au_data_1/2, au_op_sel  - drive arithunit inputs (held between ops)
//   au_data_out             - arithunit result
//   rsp_valid/rsp_ready     - response handshake
//   rsp_data, rsp_op_sel    - captured result and the op that produced it
//   busy                    - an op is in flight or commands are queued
//
// Optional feature (macro SEQ_STATS_EN):
//   stat_done  - count of response handshakes (wraps)
//   stat_stall - cycles with rsp_valid && !rsp_ready (saturates)
// ---------------------------------------------------------------------------
module arith_op_sequencer #(
   parameter int DATA_W = 16,
   parameter int OP_W   = 2,
   parameter int LAT    = 1,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_data_1,
   input  logic [DATA_W-1:0] cmd_data_2,
   input  logic [OP_W-1:0]   cmd_op_sel,
   output logic [DATA_W-1:0] au_data_1,
   output logic [DATA_W-1:0] au_data_2,
   output logic [OP_W-1:0]   au_op_sel,
   input  logic [DATA_W-1:0] au_data_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [OP_W-1:0]   rsp_op_sel,
   output logic              busy
`ifdef SEQ_STATS_EN
   ,
   output logic [15:0]       stat_done,
   output logic [15:0]       stat_stall
`endif
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = 2 * DATA_W + OP_W;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state;
   state_t next_state;

   logic [ENTRY_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W:0]     wr_ptr;
   logic [PTR_W:0]     rd_ptr;
   logic [PTR_W:0]     fifo_count;
   logic               fifo_empty;
   logic               fifo_full;
   logic [ENTRY_W-1:0] head_entry;

   logic               push;
   logic               pop;
   logic               capture;
   logic               handshake;
   logic [3:0]         cnt;

   // Pointers carry one extra wrap bit, so the difference is the true
   // occupancy and full/empty can be told apart without a separate flag.
   assign fifo_count = wr_ptr - rd_ptr;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (fifo_count == (PTR_W + 1)'(DEPTH));
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && !fifo_full;
   assign head_entry = fifo_mem[rd_ptr[PTR_W-1:0]];
   assign busy       = (state != IDLE) || !fifo_empty;

   // Storage is not reset. An entry is only read after it has been
   // written, because the pointers are reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_data_1, cmd_data_2, cmd_op_sel};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The handshake in RESP pops the next command on the same edge. This
   // keeps back-to-back ops at LAT+2 cycles, with no IDLE gap.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      capture    = 1'b0;
      handshake  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               capture    = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               handshake = 1'b1;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  next_state = WAIT;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // au_* change only on a pop. They still hold the in-flight op at capture
   // time, so au_op_sel is the op that belongs to the captured result.
   always_ff @(posedge clk) begin
      if (reset) begin
         au_data_1  <= '0;
         au_data_2  <= '0;
         au_op_sel  <= '0;
         cnt        <= 4'd0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_op_sel <= '0;
      end else begin
         if (pop) begin
            {au_data_1, au_data_2, au_op_sel} <= head_entry;
            cnt <= 4'(LAT);
         end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            rsp_data   <= au_data_out;
            rsp_op_sel <= au_op_sel;
            rsp_valid  <= 1'b1;
         end else if (handshake) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef SEQ_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_done  <= 16'd0;
         stat_stall <= 16'd0;
      end else begin
         if (handshake) begin
            stat_done <= stat_done + 16'd1;
         end
         if (rsp_valid && !rsp_ready && (stat_stall != 16'hFFFF)) begin
            stat_stall <= stat_stall + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_arith_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_arith_op_sequencer
//
// Directed bench for arith_op_sequencer. The main instance uses LAT=1 and
// a registered arithunit model. A second instance uses LAT=0 and a
// combinational model. Model ops: 0 add, 1 sub, 2 and, 3 xor.
// ---------------------------------------------------------------------------
module tb_arith_op_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_data_1;
   logic [15:0] cmd_data_2;
   logic [1:0]  cmd_op_sel;
   logic [15:0] au_data_1;
   logic [15:0] au_data_2;
   logic [1:0]  au_op_sel;
   logic [15:0] au_data_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_op_sel;
   logic        busy;

   logic        c0_valid;
   logic        c0_ready;
   logic [15:0] c0_data_1;
   logic [15:0] c0_data_2;
   logic [1:0]  c0_op_sel;
   logic [15:0] a0_data_1;
   logic [15:0] a0_data_2;
   logic [1:0]  a0_op_sel;
   logic [15:0] a0_data_out;
   logic        r0_valid;
   logic        r0_ready;
   logic [15:0] r0_data;
   logic [1:0]  r0_op_sel;
   logic        busy0;

`ifdef SEQ_STATS_EN
   logic [15:0] stat_done;
   logic [15:0] stat_stall;
   logic [15:0] stat_done0;
   logic [15:0] stat_stall0;
`endif

   int testsRun    = 0;
   int testsFailed = 0;
   int cyc         = 0;

   int gotData[$];
   int gotOp[$];
   int gotCyc[$];

   logic [15:0] expData[5];
   logic [1:0]  expOp[5];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] auFunc(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a ^ b;
      endcase
   endfunction

   always @(posedge clk) au_data_out <= auFunc(au_data_1, au_data_2, au_op_sel);

   assign a0_data_out = auFunc(a0_data_1, a0_data_2, a0_op_sel);

   arith_op_sequencer #(.DATA_W(16), .OP_W(2), .LAT(1), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_data_1(cmd_data_1), .cmd_data_2(cmd_data_2), .cmd_op_sel(cmd_op_sel),
      .au_data_1(au_data_1), .au_data_2(au_data_2), .au_op_sel(au_op_sel),
      .au_data_out(au_data_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_op_sel(rsp_op_sel), .busy(busy)
`ifdef SEQ_STATS_EN
      , .stat_done(stat_done), .stat_stall(stat_stall)
`endif
   );

   arith_op_sequencer #(.DATA_W(16), .OP_W(2), .LAT(0), .DEPTH(4)) dut0 (
      .clk(clk), .reset(reset),
      .cmd_valid(c0_valid), .cmd_ready(c0_ready),
      .cmd_data_1(c0_data_1), .cmd_data_2(c0_data_2), .cmd_op_sel(c0_op_sel),
      .au_data_1(a0_data_1), .au_data_2(a0_data_2), .au_op_sel(a0_op_sel),
      .au_data_out(a0_data_out),
      .rsp_valid(r0_valid), .rsp_ready(r0_ready),
      .rsp_data(r0_data), .rsp_op_sel(r0_op_sel), .busy(busy0)
`ifdef SEQ_STATS_EN
      , .stat_done(stat_done0), .stat_stall(stat_stall0)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Offers one command for a single edge, then withdraws it.
   task automatic applyStimulus(input logic [15:0] d1, input logic [15:0] d2, input logic [1:0] op);
      cmd_valid  = 1'b1;
      cmd_data_1 = d1;
      cmd_data_2 = d2;
      cmd_op_sel = op;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic waitRsp(input string tag);
      int n;
      n = 0;
      while (!rsp_valid && n < 30) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(rsp_valid), 32'd1);
   endtask

   // With rsp_ready high, records each response that is visible before an
   // edge. That edge is the response's handshake edge.
   task automatic collect(input int n);
      int budget;
      gotData.delete();
      gotOp.delete();
      gotCyc.delete();
      rsp_ready = 1'b1;
      budget = 0;
      while (gotData.size() < n && budget < 60) begin
         if (rsp_valid) begin
            gotData.push_back(int'(rsp_data));
            gotOp.push_back(int'(rsp_op_sel));
            gotCyc.push_back(cyc);
         end
         tick();
         budget++;
      end
      rsp_ready = 1'b0;
      checkOutput("result_count", 32'(gotData.size()), 32'(n));
   endtask

   task automatic checkResults(input string tag);
      collect(5);
      for (int i = 0; i < 5; i++) begin
         if (i < gotData.size()) begin
            checkOutput({tag, "_data"}, 32'(gotData[i]), 32'(expData[i]));
            checkOutput({tag, "_op"}, 32'(gotOp[i]), 32'(expOp[i]));
         end
      end
   endtask

   initial begin
      logic seenValid;
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_data_1 = '0;
      cmd_data_2 = '0;
      cmd_op_sel = '0;
      rsp_ready  = 1'b0;
      c0_valid   = 1'b0;
      c0_data_1  = '0;
      c0_data_2  = '0;
      c0_op_sel  = '0;
      r0_ready   = 1'b0;
      doReset();

      // Reset state
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_au_data_1", 32'(au_data_1), 32'd0);
      checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
`ifdef SEQ_STATS_EN
      checkOutput("rst_stat_done", 32'(stat_done), 32'd0);
      checkOutput("rst_stat_stall", 32'(stat_stall), 32'd0);
`endif

      // Single op: push at T, pop at T+1, result visible after T+3
      applyStimulus(16'd3, 16'd4, 2'd0);
      checkOutput("single_busy", 32'(busy), 32'd1);
      checkOutput("single_nopop_T", 32'(au_data_1), 32'd0);
      tick();
      checkOutput("single_au_d1", 32'(au_data_1), 32'd3);
      checkOutput("single_au_d2", 32'(au_data_2), 32'd4);
      checkOutput("single_valid_T1", 32'(rsp_valid), 32'd0);
      tick();
      checkOutput("single_valid_T2", 32'(rsp_valid), 32'd0);
      tick();
      checkOutput("single_valid_T3", 32'(rsp_valid), 32'd1);
      checkOutput("single_data", 32'(rsp_data), 32'd7);
      checkOutput("single_op", 32'(rsp_op_sel), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("single_valid_done", 32'(rsp_valid), 32'd0);
      checkOutput("single_busy_done", 32'(busy), 32'd0);

      // Fill/full: 5 accepted (1 in flight + 4 queued), 6th refused
      applyStimulus(16'd10, 16'd1, 2'd0);
      applyStimulus(16'd20, 16'd5, 2'd1);
      applyStimulus(16'd7, 16'd3, 2'd2);
      applyStimulus(16'd6, 16'd3, 2'd3);
      checkOutput("fill_ready_3", 32'(cmd_ready), 32'd1);
      applyStimulus(16'd100, 16'd200, 2'd0);
      checkOutput("fill_ready_full", 32'(cmd_ready), 32'd0);
      applyStimulus(16'd1, 16'd1, 2'd0);
      checkOutput("fill_ready_still", 32'(cmd_ready), 32'd0);
      expData = '{16'd11, 16'd15, 16'd3, 16'd5, 16'd300};
      expOp   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      checkResults("fill");
      for (int i = 1; i < 5; i++) begin
         if (i < gotCyc.size()) begin
            checkOutput("fill_spacing", 32'(gotCyc[i] - gotCyc[i-1]), 32'd3);
         end
      end
      tick();
      tick();
      checkOutput("fill_no_6th", 32'(rsp_valid), 32'd0);
      checkOutput("fill_busy_end", 32'(busy), 32'd0);

      // Back-pressure: 10 stall cycles in RESP with one command queued
      doReset();
      applyStimulus(16'd5, 16'd6, 2'd1);
      applyStimulus(16'd8, 16'd2, 2'd2);
      waitRsp("bp_wait");
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("bp_data_hold", 32'(rsp_data), 32'hFFFF);
         checkOutput("bp_op_hold", 32'(rsp_op_sel), 32'd1);
      end
      checkOutput("bp_valid_hold", 32'(rsp_valid), 32'd1);
      checkOutput("bp_no_pop", 32'(au_data_1), 32'd5);
`ifdef SEQ_STATS_EN
      checkOutput("bp_stat_stall", 32'(stat_stall), 32'd10);
`endif
      collect(2);
      if (gotData.size() == 2) begin
         checkOutput("bp_res0", 32'(gotData[0]), 32'hFFFF);
         checkOutput("bp_res1", 32'(gotData[1]), 32'd0);
      end
`ifdef SEQ_STATS_EN
      checkOutput("bp_stat_done", 32'(stat_done), 32'd2);
`endif
      checkOutput("bp_busy_end", 32'(busy), 32'd0);

      // Simultaneous push/pop with 2 queued
      applyStimulus(16'd1, 16'd2, 2'd0);
      applyStimulus(16'd50, 16'd8, 2'd1);
      applyStimulus(16'd12, 16'd10, 2'd2);
      waitRsp("sim_wait");
      checkOutput("sim_first", 32'(rsp_data), 32'd3);
      rsp_ready = 1'b1;
      applyStimulus(16'd15, 16'd5, 2'd3);
      rsp_ready = 1'b0;
      checkOutput("sim_ready_2", 32'(cmd_ready), 32'd1);
      applyStimulus(16'd1000, 16'd24, 2'd0);
      checkOutput("sim_ready_3", 32'(cmd_ready), 32'd1);
      applyStimulus(16'd3, 16'd9, 2'd1);
      checkOutput("sim_ready_full", 32'(cmd_ready), 32'd0);
      expData = '{16'd42, 16'd8, 16'd10, 16'd1024, 16'hFFFA};
      expOp   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      checkResults("sim");

      // Reset mid-op: WAIT with 3 commands queued
      applyStimulus(16'd1, 16'd1, 2'd0);
      applyStimulus(16'd2, 16'd2, 2'd0);
      applyStimulus(16'd3, 16'd3, 2'd0);
      applyStimulus(16'd4, 16'd4, 2'd0);
      applyStimulus(16'd5, 16'd5, 2'd0);
      waitRsp("rst_mid_wait");
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("rst_mid_inwait", 32'(au_data_1), 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rst_mid_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_au", 32'({au_data_1, au_data_2}), 32'd0);
      checkOutput("rst_mid_ready", 32'(cmd_ready), 32'd1);
      rsp_ready = 1'b1;
      seenValid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rsp_valid || busy) seenValid = 1'b1;
      end
      rsp_ready = 1'b0;
      checkOutput("rst_mid_no_stale", 32'(seenValid), 32'd0);

      // LAT=0: pop at T+1, capture at T+2
      c0_valid  = 1'b1;
      c0_data_1 = 16'd9;
      c0_data_2 = 16'd1;
      c0_op_sel = 2'd0;
      tick();
      c0_valid = 1'b0;
      checkOutput("lat0_valid_T", 32'(r0_valid), 32'd0);
      tick();
      checkOutput("lat0_au_d1", 32'(a0_data_1), 32'd9);
      checkOutput("lat0_valid_T1", 32'(r0_valid), 32'd0);
      tick();
      checkOutput("lat0_valid_T2", 32'(r0_valid), 32'd1);
      checkOutput("lat0_data", 32'(r0_data), 32'd10);
      r0_ready = 1'b1;
      tick();
      r0_ready = 1'b0;
      checkOutput("lat0_done", 32'(r0_valid), 32'd0);
      checkOutput("lat0_busy", 32'(busy0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
